// File: rtl/mygo_chan_fifo_if.sv
// Producer/consumer handshake bundle for mygo_chan_fifo.
// slave = FIFO side, master = the processes around it.
interface mygo_chan_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_close;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_eof;

  modport slave (
    input  in_data, in_valid, in_close, out_ready,
    output in_ready, out_data, out_valid, out_eof
  );

  modport master (
    output in_data, in_valid, in_close, out_ready,
    input  in_ready, out_data, out_valid, out_eof
  );
endinterface

// File: rtl/mygo_chan_fifo.sv
// Parametrised Go channel FIFO with close / end-of-stream semantics.
// Optional statistics outputs are enabled by defining MYGO_CHAN_STATS_EN.
module mygo_chan_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  mygo_chan_fifo_if.slave        ch,
  output logic [CW-1:0]          count
`ifdef MYGO_CHAN_STATS_EN
  ,
  output logic [CW-1:0]          stat_hwm,
  output logic [31:0]            stat_push_cnt,
  output logic                   stat_err_wr_closed
`endif
);

  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             closed;
  logic             push;
  logic             pop;

  // Readiness depends only on state, so a full FIFO never frees space
  // for a push in the same cycle as a pop.
  assign ch.in_ready  = (count != FULL) && !closed;
  assign ch.out_valid = (count != '0);
  assign ch.out_eof   = closed && (count == '0);
  assign ch.out_data  = mem[rd_ptr];

  assign push = ch.in_valid && ch.in_ready;
  assign pop  = ch.out_valid && ch.out_ready;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= ch.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      closed <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // A push accepted alongside the close strobe is still buffered above.
      if (ch.in_close) begin
        closed <= 1'b1;
      end
    end
  end

`ifdef MYGO_CHAN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hwm           <= '0;
      stat_push_cnt      <= '0;
      stat_err_wr_closed <= 1'b0;
    end else begin
      if (count > stat_hwm) begin
        stat_hwm <= count;
      end
      if (push) begin
        stat_push_cnt <= stat_push_cnt + 32'd1;
      end
      if (ch.in_valid && closed) begin
        stat_err_wr_closed <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mygo_chan_fifo.sv
// Directed bench for mygo_chan_fifo across several WIDTH/DEPTH shapes;
// statistics checks compile in when MYGO_CHAN_STATS_EN is defined.
module tb_mygo_chan_fifo;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mygo_chan_fifo_if #(.WIDTH(32)) c0 ();
  mygo_chan_fifo_if #(.WIDTH(8))  c1 ();
  mygo_chan_fifo_if #(.WIDTH(8))  c2 ();
  mygo_chan_fifo_if #(.WIDTH(1))  c3 ();
  mygo_chan_fifo_if #(.WIDTH(8))  c4 ();

  logic [0:0] cnt0;
  logic [3:0] cnt1;
  logic [1:0] cnt2;
  logic [0:0] cnt3;
  logic [2:0] cnt4;

`ifdef MYGO_CHAN_STATS_EN
  logic [0:0] hwm0;  logic [31:0] pc0;  logic err0;
  logic [3:0] hwm1;  logic [31:0] pc1;  logic err1;
  logic [1:0] hwm2;  logic [31:0] pc2;  logic err2;
  logic [0:0] hwm3;  logic [31:0] pc3;  logic err3;
  logic [2:0] hwm4;  logic [31:0] pc4;  logic err4;
`endif

  mygo_chan_fifo #(.WIDTH(32), .DEPTH(1)) u0 (
    .clk(clk), .rst(rst), .ch(c0), .count(cnt0)
`ifdef MYGO_CHAN_STATS_EN
    , .stat_hwm(hwm0), .stat_push_cnt(pc0), .stat_err_wr_closed(err0)
`endif
  );
  mygo_chan_fifo #(.WIDTH(8), .DEPTH(8)) u1 (
    .clk(clk), .rst(rst), .ch(c1), .count(cnt1)
`ifdef MYGO_CHAN_STATS_EN
    , .stat_hwm(hwm1), .stat_push_cnt(pc1), .stat_err_wr_closed(err1)
`endif
  );
  mygo_chan_fifo #(.WIDTH(8), .DEPTH(3)) u2 (
    .clk(clk), .rst(rst), .ch(c2), .count(cnt2)
`ifdef MYGO_CHAN_STATS_EN
    , .stat_hwm(hwm2), .stat_push_cnt(pc2), .stat_err_wr_closed(err2)
`endif
  );
  mygo_chan_fifo #(.WIDTH(1), .DEPTH(1)) u3 (
    .clk(clk), .rst(rst), .ch(c3), .count(cnt3)
`ifdef MYGO_CHAN_STATS_EN
    , .stat_hwm(hwm3), .stat_push_cnt(pc3), .stat_err_wr_closed(err3)
`endif
  );
  mygo_chan_fifo #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .ch(c4), .count(cnt4)
`ifdef MYGO_CHAN_STATS_EN
    , .stat_hwm(hwm4), .stat_push_cnt(pc4), .stat_err_wr_closed(err4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    c0.in_data = '0; c0.in_valid = 0; c0.in_close = 0; c0.out_ready = 0;
    c1.in_data = '0; c1.in_valid = 0; c1.in_close = 0; c1.out_ready = 0;
    c2.in_data = '0; c2.in_valid = 0; c2.in_close = 0; c2.out_ready = 0;
    c3.in_data = '0; c3.in_valid = 0; c3.in_close = 0; c3.out_ready = 0;
    c4.in_data = '0; c4.in_valid = 0; c4.in_close = 0; c4.out_ready = 0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(c0.out_valid), 64'd0);
    chk("rst_out_eof",   64'(c0.out_eof),   64'd0);
    chk("rst_in_ready",  64'(c0.in_ready),  64'd1);
    chk("rst_count",     64'(cnt0),         64'd0);
    chk("rst_d8_ready",  64'(c1.in_ready),  64'd1);

    // W32 D1: single element, 1-cycle latency, 50% throughput
    c0.in_valid = 1; c0.in_data = 32'h4; c0.out_ready = 1;
    step();
    c0.in_valid = 0;
    chk("d1_out_valid", 64'(c0.out_valid), 64'd1);
    chk("d1_out_data",  64'(c0.out_data),  64'h4);
    chk("d1_in_ready",  64'(c0.in_ready),  64'd0);
    chk("d1_count1",    64'(cnt0),         64'd1);
    step();
    chk("d1_drained",   64'(c0.out_valid), 64'd0);
    chk("d1_ready_back",64'(c0.in_ready),  64'd1);
    chk("d1_count0",    64'(cnt0),         64'd0);
    c0.out_ready = 0;

    // W8 D8: fill, stall, wrap, drain in order
    for (int i = 0; i < 8; i++) begin
      c1.in_valid = 1; c1.in_data = 8'(i);
      step();
    end
    chk("d8_full_ready", 64'(c1.in_ready), 64'd0);
    chk("d8_full_count", 64'(cnt1),        64'd8);
    chk("d8_head0",      64'(c1.out_data), 64'h00);
    c1.in_data = 8'h08; c1.out_ready = 1;
    step();
    chk("d8_no_push_when_full", 64'(cnt1), 64'd7);
    chk("d8_head1",      64'(c1.out_data), 64'h01);
    chk("d8_ready_again",64'(c1.in_ready), 64'd1);
    step();
    chk("d8_count_pp",   64'(cnt1),        64'd7);
    chk("d8_head2",      64'(c1.out_data), 64'h02);
    c1.in_data = 8'h09;
    step();
    c1.in_valid = 0;
    chk("d8_count_pp2",  64'(cnt1),        64'd7);
    for (int k = 3; k <= 9; k++) begin
      chk("d8_order_valid", 64'(c1.out_valid), 64'd1);
      chk("d8_order_data",  64'(c1.out_data),  64'(k));
      step();
    end
    chk("d8_empty",      64'(c1.out_valid), 64'd0);
    chk("d8_count_end",  64'(cnt1),         64'd0);
    c1.out_ready = 0;

    // W8 D3: continuous stream, count holds at 1
    c2.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      c2.in_valid = 1; c2.in_data = 8'(i + 8'h30);
      step();
      chk("d3_count", 64'(cnt2),        64'd1);
      chk("d3_data",  64'(c2.out_data), 64'(i + 8'h30));
    end
    c2.in_valid = 0;
    step();
    chk("d3_drained", 64'(cnt2), 64'd0);
    c2.out_ready = 0;

    // W1 D1: push with close in the same cycle, then eof
    c3.in_valid = 1; c3.in_data = 1'b1; c3.in_close = 1;
    step();
    c3.in_close = 0;
    chk("cl_out_valid", 64'(c3.out_valid), 64'd1);
    chk("cl_out_data",  64'(c3.out_data),  64'd1);
    chk("cl_in_ready",  64'(c3.in_ready),  64'd0);
    chk("cl_no_eof",    64'(c3.out_eof),   64'd0);
    c3.out_ready = 1;
    step();
    chk("cl_eof",       64'(c3.out_eof),   64'd1);
    chk("cl_empty",     64'(c3.out_valid), 64'd0);
    chk("cl_ready_low", 64'(c3.in_ready),  64'd0);
    step();
    chk("cl_no_write",  64'(cnt3),         64'd0);
    chk("cl_eof_hold",  64'(c3.out_eof),   64'd1);
    c3.in_valid = 0; c3.out_ready = 0;

    // W8 D4: reset discards data and closed flag
    c4.in_valid = 1; c4.in_data = 8'hA1;
    step();
    c4.in_data = 8'hA2;
    step();
    c4.in_data = 8'hA3; c4.in_close = 1;
    step();
    c4.in_valid = 0; c4.in_close = 0;
    chk("rm_count3",  64'(cnt4),         64'd3);
    chk("rm_closed",  64'(c4.in_ready),  64'd0);
    chk("rm_head",    64'(c4.out_data),  64'hA1);
    rst = 1;
    step();
    rst = 0;
    chk("rm_count0",  64'(cnt4),         64'd0);
    chk("rm_valid0",  64'(c4.out_valid), 64'd0);
    chk("rm_eof0",    64'(c4.out_eof),   64'd0);
    chk("rm_ready1",  64'(c4.in_ready),  64'd1);

`ifdef MYGO_CHAN_STATS_EN
    // Stats: fill to 5, drain, close, write while closed
    chk("st_hwm_rst", 64'(hwm1), 64'd0);
    for (int i = 0; i < 5; i++) begin
      c1.in_valid = 1; c1.in_data = 8'(i + 8'h10);
      step();
    end
    c1.in_valid = 0;
    chk("st_count5", 64'(cnt1), 64'd5);
    c1.out_ready = 1;
    for (int i = 0; i < 5; i++) step();
    c1.out_ready = 0;
    chk("st_count0", 64'(cnt1), 64'd0);
    chk("st_err_pre", 64'(err1), 64'd0);
    c1.in_close = 1;
    step();
    c1.in_close = 0; c1.in_valid = 1;
    step();
    c1.in_valid = 0;
    chk("st_hwm",      64'(hwm1), 64'd5);
    chk("st_push_cnt", 64'(pc1),  64'd5);
    chk("st_err",      64'(err1), 64'd1);
    chk("st_eof",      64'(c1.out_eof), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mygo_chan_fifo.md
Name: mygo_chan_fifo

Overview:
- Parametrised successor to the fixed-shape channel FIFOs (i32_d1, i8_d8, i1_d1) instantiated per Go channel by the compiler.
- One module covers any element width and buffer depth, and adds Go close semantics: close strobe, end-of-stream indication, occupancy count.
- Sits between a producer process (`chan_*_w*` signals) and a consumer process (`chan_*_r*` signals) in the generated top module.

Parameters:
- WIDTH, 32, element width in bits (>=1).
- DEPTH, 1, buffer capacity in elements (>=1, not required to be a power of two).
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  producer element.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO accepts in_data this cycle.
- in_close  in  1  single-cycle strobe: producer closes the channel.
- out_data  out  WIDTH  head element.
- out_valid  out  1  head element is valid.
- out_ready  in  1  consumer takes head this cycle.
- out_eof  out  1  channel is closed and drained (Go `ok == false`).
- count  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset:
  - When rst is sampled high: count=0, rd/wr pointers=0, closed=0.
  - Resulting outputs: out_valid=0, out_eof=0, in_ready=1.
  - out_data is don't-care while out_valid=0.
  - Reset mid-operation discards all buffered data and the closed flag.
- Push: in_valid && in_ready at edge N:
  - Element written at wr_ptr.
  - wr_ptr wraps from DEPTH-1 to 0.
- Pop: out_valid && out_ready at edge N:
  - rd_ptr advances with the same wrap rule.
- Storage and latency:
  - out_data is driven from the storage array at rd_ptr; no output register.
  - Element pushed at edge N is visible with out_valid=1 in cycle N+1 (1-cycle latency).
  - No combinational in->out bypass.
- in_ready = (count != DEPTH) && !closed.
  - No dependency on out_ready.
  - When full, a same-cycle pop does NOT free space for a push; the producer waits one cycle.
- out_valid = (count != 0); never depends on in_valid.
- Simultaneous push and pop (count strictly between 0 and DEPTH): count unchanged, both pointers advance.
- count update: +1 on push only, -1 on pop only, otherwise unchanged. It never exceeds DEPTH and never underflows.
- Close:
  - in_close at edge N sets closed from cycle N+1.
  - A push accepted in the same cycle as in_close is kept; data is ordered before close.
  - in_close while already closed has no effect.
- out_eof = closed && (count == 0); combinational from state.
  - The consumer drains remaining elements normally after close.
- Writes after close: in_ready=0, so they are never accepted. The producer stalls, matching Go's blocked write semantics. A sticky error is available only with the optional feature.
- DEPTH=1 degenerates to a single-entry register slice with 50% throughput under a continuous stream. Full throughput requires DEPTH>=2.

Optional Feature:
- Macro: MYGO_CHAN_STATS_EN.
- Defined: adds three outputs:
  - stat_hwm [CW-1:0]: high-water mark of count. Updated the cycle after count rises above it; cleared by rst.
  - stat_push_cnt [31:0]: count of accepted pushes; wraps at 2^32.
  - stat_err_wr_closed [1]: sticky, set when in_valid=1 while closed=1; cleared only by rst.
- Not defined: these ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- WIDTH=32, DEPTH=1: push 0x4 at cycle 1, out_ready=1 -> out_valid=1, out_data=0x4 in cycle 2; in_ready=0 in cycle 2 and 1 again in cycle 3; count 0->1->0.
- WIDTH=8, DEPTH=8: push 0x00..0x09 with out_ready=0 -> in_ready drops after 8th push, count=8; then out_ready=1 -> pops 0x00..0x07 in order, 0x08 and 0x09 follow after space frees, pointers wrap correctly.
- WIDTH=8, DEPTH=3 (non-power-of-two): continuous push and pop for 20 elements of incrementing data -> no loss or reorder; count stays 1 after the first element.
- WIDTH=1, DEPTH=1: push 1 with in_close in the same cycle -> element 1 delivered, then out_eof=1; in_ready stays 0; further in_valid is not accepted.
- Reset mid-stream: DEPTH=4 holding 3 elements, closed=1, assert rst for 1 cycle -> next cycle count=0, out_valid=0, out_eof=0, in_ready=1.
- MYGO_CHAN_STATS_EN build: fill DEPTH=8 to 5 and drain, close, then drive in_valid=1 -> stat_hwm=5, stat_push_cnt=5, stat_err_wr_closed=1.
